sram_frame_arbiter: RTL and testbench
=====================================

// Module: sram_frame_arbiter
// PURPOSE
//  Sole owner of the external SRAM port. Shares it between the VGA scan-out reader and a pixel writer
//  (renderer / console painter), and manages double buffering: front buffer is scanned out, back buffer
//  is written. Writer traffic is buffered in a small FIFO and drained in display idle cycles; buffers
//  swap only during vertical blanking, so scan-out never shows a half-painted frame.
// PARAMETERS
//  FIFO_DEPTH    16      write FIFO entries, power of two, >=2
//  BUFFER0_BASE  0       SRAM word address of frame buffer 0 (front after reset)
//  BUFFER1_BASE  307200  SRAM word address of frame buffer 1 (640*480; back after reset)
// PORTS
//  clk            in   1               system/pixel clock
//  rst            in   1               asynchronous, active-high reset
//  dispReq        in   SramRequest_t   scan-out read request (den=0, we_n=1, oe_n=0 when reading)
//  dispResult     out  SramResult_t    SRAM result forwarded to scan-out
//  dispPaintDone  in   1               high while scan-out is in vertical blanking
//  frontBase      out  SramAddress_t   base address the scan-out must read from
//  wrValid        in   1               writer has a pixel to write
//  wrReady        out  1               FIFO accepts pixel this cycle
//  wrOffset       in   SramAddress_t   pixel offset within the back buffer
//  wrData         in   SramData_t      pixel word
//  swapReq        in   1               one-cycle pulse: back buffer complete, request swap
//  swapAck        out  1               one-cycle pulse: swap performed
//  ramRequest     out  SramRequest_t   to SRAM controller
//  ramResult      in   SramResult_t    from SRAM controller
// BEHAVIOUR
//  Reset: frontBase=BUFFER0_BASE, backBase=BUFFER1_BASE, FIFO empty, wrReady=0, swapAck=0,
//   ramRequest idle (oe_n=1, we_n=1, den=0, address=0), state=IDLE. Any in-progress swap is abandoned.
//  Arbitration (combinational, per cycle), fixed priority:
//   1) dispReq.oe_n==0 -> ramRequest=dispReq unchanged (display never stalls, zero added latency).
//   2) else FIFO non-empty -> pop head; ramRequest: address=backBase+offset, dout=data, den=1, we_n=0, oe_n=1.
//   3) else idle request.
//  dispResult=ramResult always (write-cycle done is ignored by scan-out, which has oe_n=1 then).
//  Write address addition is SramAddress_t width, wraps modulo 2^width; no range check on wrOffset.
//  FIFO: push when wrValid&wrReady; pop as in 2). Push and pop same cycle allowed, including when
//   full (pop frees slot, but wrReady is computed from registered count, so full -> wrReady=0).
//  wrReady = !rst & !full & (state==IDLE). Data order through FIFO preserved.
//  FSM:
//   IDLE     : swapReq -> DRAIN.
//   DRAIN    : writes blocked (wrReady=0); FIFO keeps draining. FIFO empty -> WAIT_VB.
//   WAIT_VB  : dispPaintDone==1 -> SWAP (also taken if already in blanking).
//   SWAP     : one cycle: exchange frontBase/backBase, swapAck=1 -> IDLE.
//  swapReq outside IDLE is ignored (no queueing). frontBase changes only on SWAP->IDLE edge, which only
//   follows a cycle with dispPaintDone=1, so the scan-out sees a single base for a whole active frame.
//  Writer may resume pushing the cycle after swapAck; those writes target the new back buffer.
// STRUCTURE
//  Shared package (DataType.svh): SramAddress_t, SramData_t, SramRequest_t, SramResult_t,
//   SRAM_IDLE_REQUEST constant, ArbState_t enum {IDLE, DRAIN, WAIT_VB, SWAP}.
//  Sub-module: sync_fifo (parameterised width/depth, registered count, full/empty flags) holding
//   {offset, data}; arbiter mux and FSM live in this module.
// TESTING
//  Reset then push 3 writes (off 0,1,2; data A,B,C) with dispReq idle -> SRAM writes to 307200..307202,
//   one per cycle, order A,B,C, we_n=0/den=1 each.
//  Hold dispReq.oe_n=0 for 20 cycles while pushing 16 writes -> no writes issued, wrReady=0 after 16th,
//   display requests forwarded bit-exact; all 16 drain in 16 cycles after release.
//  swapReq with 4 FIFO entries, dispPaintDone=0 -> wrReady=0, entries drain, no swap until
//   dispPaintDone=1; then swapAck one cycle later, frontBase=307200, next writes go to base 0.
//  Second swapReq while in WAIT_VB -> ignored, exactly one swapAck; subsequent swap returns frontBase=0.
//  Assert rst during DRAIN with entries queued -> FIFO flushed, frontBase=0, no SRAM write after rst.
//  Push and pop same cycle at count=FIFO_DEPTH-1 -> count unchanged, no data loss or duplication.

Source files
------------

// File: rtl/sram_frame_arbiter_pkg.sv
// Shared SRAM types, request constants and
// arbiter state encoding for the frame arbiter.
package sram_frame_arbiter_pkg;

  localparam int SRAM_ADDR_W = 20;
  localparam int SRAM_DATA_W = 16;

  typedef logic [SRAM_ADDR_W-1:0] SramAddress_t;
  typedef logic [SRAM_DATA_W-1:0] SramData_t;

  typedef struct packed {
    SramAddress_t address;
    SramData_t    dout;
    logic         den;
    logic         we_n;
    logic         oe_n;
  } SramRequest_t;

  typedef struct packed {
    SramData_t din;
    logic      done;
  } SramResult_t;

  localparam SramRequest_t SRAM_IDLE_REQUEST = '{
    address: '0,
    dout:    '0,
    den:     1'b0,
    we_n:    1'b1,
    oe_n:    1'b1
  };

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    WAIT_VB,
    SWAP
  } ArbState_t;

  // One queued pixel write.
  typedef struct packed {
    SramAddress_t offset;
    SramData_t    data;
  } WrEntry_t;

  localparam int WR_ENTRY_W = $bits(WrEntry_t);

  // Back-buffer write; the address wraps modulo 2^SRAM_ADDR_W.
  function automatic SramRequest_t write_request(
    input SramAddress_t base,
    input WrEntry_t     e
  );
    SramRequest_t r;
    r.address = base + e.offset;
    r.dout    = e.data;
    r.den     = 1'b1;
    r.we_n    = 1'b0;
    r.oe_n    = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/sram_frame_arbiter_sync_fifo.sv
// First-word-fall-through synchronous FIFO
// with a registered occupancy count.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW:0]   CNT_MAX = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == CNT_MAX);
  assign empty_o = (count_q == '0);
  assign rdata_o = mem_q[rd_ptr_q];

  // Guard the handshakes and compute next pointers/count.
  always_comb begin
    do_push  = push_i && !full_o;
    do_pop   = pop_i && !empty_o;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Storage array, no reset needed.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  // Pointer and count registers; reset flushes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/sram_frame_arbiter.sv
// SRAM port owner: scan-out reads win, queued
// pixel writes fill idle cycles, swaps in vblank.
module sram_frame_arbiter
  import sram_frame_arbiter_pkg::*;
#(
  parameter int           FIFO_DEPTH   = 16,
  parameter SramAddress_t BUFFER0_BASE = '0,
  parameter SramAddress_t BUFFER1_BASE = SramAddress_t'(307200)
) (
  input  logic         clk,
  input  logic         rst,
  input  SramRequest_t dispReq,
  output SramResult_t  dispResult,
  input  logic         dispPaintDone,
  output SramAddress_t frontBase,
  input  logic         wrValid,
  output logic         wrReady,
  input  SramAddress_t wrOffset,
  input  SramData_t    wrData,
  input  logic         swapReq,
  output logic         swapAck,
  output SramRequest_t ramRequest,
  input  SramResult_t  ramResult
);

  ArbState_t    state_q, state_d;
  SramAddress_t front_q, front_d;
  SramAddress_t back_q, back_d;
  logic         swap_en;

  logic         fifo_push;
  logic         fifo_pop;
  logic         fifo_full;
  logic         fifo_empty;
  WrEntry_t     fifo_wdata;
  WrEntry_t     fifo_head;

  assign fifo_push  = wrValid && wrReady;
  assign fifo_wdata = '{offset: wrOffset, data: wrData};

  sync_fifo #(
    .WIDTH (WR_ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .wdata_i (fifo_wdata),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign dispResult = ramResult;
  assign frontBase  = front_q;

  // Port mux: display read, else FIFO head, else idle.
  always_comb begin
    ramRequest = SRAM_IDLE_REQUEST;
    fifo_pop   = 1'b0;
    if (!rst) begin
      if (!dispReq.oe_n) begin
        ramRequest = dispReq;
      end else if (!fifo_empty) begin
        fifo_pop   = 1'b1;
        ramRequest = write_request(back_q, fifo_head);
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state; swapReq outside IDLE is dropped.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (swapReq)       state_d = DRAIN;
      DRAIN:   if (fifo_empty)    state_d = WAIT_VB;
      WAIT_VB: if (dispPaintDone) state_d = SWAP;
      SWAP:                       state_d = IDLE;
      default:                    state_d = IDLE;
    endcase
  end

  // FSM outputs: writer gate, ack pulse, swap strobe.
  always_comb begin
    wrReady = 1'b0;
    swapAck = 1'b0;
    swap_en = 1'b0;
    unique case (state_q)
      IDLE: wrReady = !rst && !fifo_full;
      SWAP: begin
        swapAck = 1'b1;
        swap_en = 1'b1;
      end
      default: ;
    endcase
  end

  // Exchange buffers as SWAP is left.
  always_comb begin
    front_d = swap_en ? back_q  : front_q;
    back_d  = swap_en ? front_q : back_q;
  end

  // Buffer base registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      front_q <= BUFFER0_BASE;
      back_q  <= BUFFER1_BASE;
    end else begin
      front_q <= front_d;
      back_q  <= back_d;
    end
  end

endmodule

// File: tb/tb_sram_frame_arbiter.sv
// Directed bench for sram_frame_arbiter:
// arbitration, FIFO order, swap FSM, reset.
module tb_sram_frame_arbiter;
  import sram_frame_arbiter_pkg::*;

  logic         clk;
  logic         rst;
  SramRequest_t dispReq;
  SramResult_t  dispResult;
  logic         dispPaintDone;
  SramAddress_t frontBase;
  logic         wrValid;
  logic         wrReady;
  SramAddress_t wrOffset;
  SramData_t    wrData;
  logic         swapReq;
  logic         swapAck;
  SramRequest_t ramRequest;
  SramResult_t  ramResult;

  int checks = 0;
  int errors = 0;

  localparam SramAddress_t B0 = SramAddress_t'(0);
  localparam SramAddress_t B1 = SramAddress_t'(307200);

  sram_frame_arbiter dut (
    .clk           (clk),
    .rst           (rst),
    .dispReq       (dispReq),
    .dispResult    (dispResult),
    .dispPaintDone (dispPaintDone),
    .frontBase     (frontBase),
    .wrValid       (wrValid),
    .wrReady       (wrReady),
    .wrOffset      (wrOffset),
    .wrData        (wrData),
    .swapReq       (swapReq),
    .swapAck       (swapAck),
    .ramRequest    (ramRequest),
    .ramResult     (ramResult)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic SramRequest_t wr(input int a, input int d);
    SramRequest_t r;
    r.address = SramAddress_t'(a);
    r.dout    = SramData_t'(d);
    r.den     = 1'b1;
    r.we_n    = 1'b0;
    r.oe_n    = 1'b1;
    return r;
  endfunction

  function automatic SramRequest_t rd(input int a);
    SramRequest_t r;
    r.address = SramAddress_t'(a);
    r.dout    = '0;
    r.den     = 1'b0;
    r.we_n    = 1'b1;
    r.oe_n    = 1'b0;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic chk_rq(input string tag, input SramRequest_t e);
    chk(tag, 64'(ramRequest), 64'(e));
  endtask

  task automatic chk_b(input string tag, input logic o, input logic e);
    chk(tag, 64'(o), 64'(e));
  endtask

  task automatic chk_a(input string tag, input SramAddress_t o,
                       input SramAddress_t e);
    chk(tag, 64'(o), 64'(e));
  endtask

  task automatic chk_cnt(input string tag, input int e);
    chk(tag, 64'(dut.u_fifo.count_q), 64'(e));
  endtask

  // Swap with empty FIFO and vblank already active.
  task automatic quick_swap(input SramAddress_t exp_front);
    dispPaintDone = 1'b1;
    swapReq = 1'b1;
    settle();
    tick();
    swapReq = 1'b0;
    settle();
    chk_b("qs_drain_ack", swapAck, 1'b0);
    chk_b("qs_drain_rdy", wrReady, 1'b0);
    tick();
    settle();
    chk_b("qs_wait_ack", swapAck, 1'b0);
    tick();
    settle();
    chk_b("qs_swap_ack", swapAck, 1'b1);
    tick();
    settle();
    chk_b("qs_idle_ack", swapAck, 1'b0);
    chk_a("qs_front", frontBase, exp_front);
    dispPaintDone = 1'b0;
  endtask

  initial begin
    rst           = 1'b1;
    dispReq       = rd(32'h55);
    dispPaintDone = 1'b0;
    wrValid       = 1'b0;
    wrOffset      = '0;
    wrData        = '0;
    swapReq       = 1'b0;
    ramResult     = '0;
    #3;
    chk_a("rst_front", frontBase, B0);
    chk_b("rst_wrReady", wrReady, 1'b0);
    chk_b("rst_swapAck", swapAck, 1'b0);
    chk_rq("rst_ram_idle", SRAM_IDLE_REQUEST);

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    dispReq = SRAM_IDLE_REQUEST;
    ramResult = '{din: 16'hBEEF, done: 1'b1};
    settle();
    chk_b("post_rst_wrReady", wrReady, 1'b1);
    chk_rq("post_rst_idle", SRAM_IDLE_REQUEST);
    chk("result_pass", 64'(dispResult), 64'({16'hBEEF, 1'b1}));
    ramResult = '{din: 16'h1234, done: 1'b0};
    settle();
    chk("result_pass2", 64'(dispResult), 64'({16'h1234, 1'b0}));
    tick();

    // Three writes in idle display cycles.
    wrValid = 1'b1; wrOffset = 20'd0; wrData = 16'h000A;
    settle();
    chk_rq("w3_c0_idle", SRAM_IDLE_REQUEST);
    tick();
    wrOffset = 20'd1; wrData = 16'h000B;
    settle();
    chk_rq("w3_A", wr(307200, 16'h000A));
    tick();
    wrOffset = 20'd2; wrData = 16'h000C;
    settle();
    chk_rq("w3_B", wr(307201, 16'h000B));
    tick();
    wrValid = 1'b0;
    settle();
    chk_rq("w3_C", wr(307202, 16'h000C));
    tick();
    settle();
    chk_rq("w3_done_idle", SRAM_IDLE_REQUEST);
    tick();

    // Display holds the port for 20 cycles.
    for (int i = 0; i < 20; i++) begin
      dispReq  = rd(100 + i);
      wrValid  = (i < 16);
      wrOffset = SramAddress_t'(20 + i);
      wrData   = SramData_t'(16'h1000 + i);
      settle();
      chk_rq("disp_fwd", rd(100 + i));
      chk_b("disp_wrReady", wrReady, i < 16);
      tick();
    end
    dispReq = SRAM_IDLE_REQUEST;
    wrValid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      settle();
      chk_rq("drain16", wr(307220 + i, 16'h1000 + i));
      tick();
    end
    settle();
    chk_rq("drain16_idle", SRAM_IDLE_REQUEST);
    tick();

    // Push and pop together at DEPTH-1.
    for (int i = 0; i < 15; i++) begin
      dispReq  = rd(200 + i);
      wrValid  = 1'b1;
      wrOffset = SramAddress_t'(16'h40 + i);
      wrData   = SramData_t'(16'h2000 + i);
      settle();
      tick();
    end
    dispReq  = SRAM_IDLE_REQUEST;
    wrOffset = 20'h4F;
    wrData   = 16'h200F;
    settle();
    chk_cnt("pp_cnt_before", 15);
    chk_b("pp_wrReady", wrReady, 1'b1);
    chk_rq("pp_pop0", wr(307200 + 16'h40, 16'h2000));
    tick();
    wrValid = 1'b0;
    settle();
    chk_cnt("pp_cnt_after", 15);
    chk_rq("pp_pop1", wr(307200 + 16'h41, 16'h2001));
    tick();
    for (int i = 2; i < 16; i++) begin
      settle();
      chk_rq("pp_drain", wr(307200 + 16'h40 + i, 16'h2000 + i));
      tick();
    end
    settle();
    chk_rq("pp_idle", SRAM_IDLE_REQUEST);
    chk_cnt("pp_cnt_empty", 0);
    tick();

    // Swap with 4 entries queued, vblank late.
    for (int i = 0; i < 4; i++) begin
      dispReq  = rd(300 + i);
      wrValid  = 1'b1;
      wrOffset = SramAddress_t'(10 + i);
      wrData   = SramData_t'(16'h3000 + i);
      settle();
      tick();
    end
    wrValid = 1'b0;
    swapReq = 1'b1;
    settle();
    chk_b("sw_req_rdy", wrReady, 1'b1);
    tick();
    swapReq  = 1'b0;
    dispReq  = SRAM_IDLE_REQUEST;
    wrValid  = 1'b1;
    wrOffset = 20'd99;
    wrData   = 16'hDEAD;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk_b("sw_drain_rdy", wrReady, 1'b0);
      chk_rq("sw_drain_wr", wr(307210 + i, 16'h3000 + i));
      chk_b("sw_drain_ack", swapAck, 1'b0);
      tick();
    end
    wrValid = 1'b0;
    settle();
    chk_rq("sw_empty_idle", SRAM_IDLE_REQUEST);
    chk_b("sw_empty_rdy", wrReady, 1'b0);
    tick();
    for (int i = 0; i < 3; i++) begin
      swapReq = (i == 1);
      settle();
      chk_b("sw_wait_ack", swapAck, 1'b0);
      chk_a("sw_wait_front", frontBase, B0);
      tick();
    end
    swapReq = 1'b0;
    dispPaintDone = 1'b1;
    settle();
    chk_b("sw_vb_ack", swapAck, 1'b0);
    tick();
    dispPaintDone = 1'b0;
    settle();
    chk_b("sw_ack", swapAck, 1'b1);
    chk_a("sw_ack_front", frontBase, B0);
    chk_b("sw_ack_rdy", wrReady, 1'b0);
    tick();
    wrValid  = 1'b1;
    wrOffset = 20'd5;
    wrData   = 16'h5555;
    settle();
    chk_b("sw_after_ack", swapAck, 1'b0);
    chk_a("sw_after_front", frontBase, B1);
    chk_b("sw_after_rdy", wrReady, 1'b1);
    tick();
    wrValid = 1'b0;
    settle();
    chk_rq("sw_newback_wr", wr(5, 16'h5555));
    tick();
    for (int i = 0; i < 3; i++) begin
      settle();
      chk_rq("sw_no_dead", SRAM_IDLE_REQUEST);
      chk_b("sw_one_ack", swapAck, 1'b0);
      chk_b("sw_stay_idle", wrReady, 1'b1);
      tick();
    end

    quick_swap(B0);
    tick();
    quick_swap(B1);
    tick();

    // Reset in DRAIN with entries queued.
    for (int i = 0; i < 3; i++) begin
      dispReq  = rd(400 + i);
      wrValid  = 1'b1;
      wrOffset = SramAddress_t'(7 + i);
      wrData   = SramData_t'(16'h7000 + i);
      settle();
      tick();
    end
    wrValid = 1'b0;
    swapReq = 1'b1;
    settle();
    tick();
    swapReq = 1'b0;
    settle();
    chk_b("rd_drain_rdy", wrReady, 1'b0);
    chk_cnt("rd_cnt_queued", 3);
    chk_a("rd_front_pre", frontBase, B1);
    rst = 1'b1;
    dispReq = SRAM_IDLE_REQUEST;
    #1;
    chk_rq("rd_in_rst_idle", SRAM_IDLE_REQUEST);
    chk_a("rd_in_rst_front", frontBase, B0);
    chk_cnt("rd_in_rst_cnt", 0);
    chk_b("rd_in_rst_rdy", wrReady, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk_rq("rd_no_write", SRAM_IDLE_REQUEST);
      chk_b("rd_rdy", wrReady, 1'b1);
      chk_a("rd_front", frontBase, B0);
      tick();
    end
    wrValid  = 1'b1;
    wrOffset = 20'd1;
    wrData   = 16'h1111;
    settle();
    tick();
    wrValid = 1'b0;
    settle();
    chk_rq("rd_back_reset", wr(307201, 16'h1111));
    tick();
    settle();
    chk_rq("rd_final_idle", SRAM_IDLE_REQUEST);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
